// File: rtl/hazard_pkg.sv
// Shared pipeline-entry type, bubble constant and index-width helper for the hazard scoreboard.
// Latency: none (types and constants only).
// Backpressure: none; optional macro HAZARD_ZERO_REG_EN is interpreted by the modules importing this package.
package hazard_pkg;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int MAX_RAL = 8;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic               is_load;
    logic [MAX_RAL-1:0] rd;
  } entry_t;

  // An empty pipeline slot.
  localparam entry_t BUBBLE = '0;

  // IDX_W = $clog2(NUM_STAGES), kept at least 1 bit so a single-stage build still has an index.
  function automatic int idx_w(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// fwd_select: per-read-port forwarding mux and load-use hazard detect over all in-flight entries.
// Latency: purely combinational, zero cycles.
// Backpressure: none itself; raises hazard so the top can stall ID. Honours HAZARD_ZERO_REG_EN.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int NUM_STAGES         = 3
) (
  input  logic [REG_ADDRESS_LENGTH-1:0]    src,
  input  logic                             src_used,
  input  entry_t [NUM_STAGES-1:0]          entries,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_result,
  input  logic [DATA_WIDTH-1:0]            rf_data,
  output logic [DATA_WIDTH-1:0]            opnd_data,
  output logic                             hazard
);

  localparam int IDX_W = idx_w(NUM_STAGES);

  logic [MAX_RAL-1:0]    src_ext;
  logic                  src_zero;
  logic [NUM_STAGES-1:0] match;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;

  // Compare the source address against every live writing entry.
  always_comb begin
    src_ext = '0;
    src_ext[REG_ADDRESS_LENGTH-1:0] = src;
`ifdef HAZARD_ZERO_REG_EN
    src_zero = (src == '0);
`else
    src_zero = 1'b0;
`endif
    for (int s = 0; s < NUM_STAGES; s++) begin
      match[s] = src_used & ~src_zero & entries[s].valid & entries[s].wr_en &
                 (entries[s].rd == src_ext);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; any un-retired load match is a hazard.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hazard  = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (match[s]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(s);
      end
      if (match[s] && entries[s].is_load && (s < NUM_STAGES - 1)) begin
        hazard = 1'b1;
      end
    end
  end

  // Operand select: hard zero, forwarded stage result, or register file.
  always_comb begin
    if (src_zero) begin
      opnd_data = '0;
    end else if (hit) begin
      opnd_data = stage_result[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      opnd_data = rf_data;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks NUM_STAGES in-flight writes after ID, forwards operands, stalls ID on load-use.
// Latency: forwarding and id_ready are combinational; wb_en/wb_rd come straight from the oldest entry.
// Backpressure: id_ready drops while a consumed source waits on a load; older stages never freeze. Macro: HAZARD_ZERO_REG_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int NUM_STAGES         = 3,
  parameter int NUM_READ           = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic                                 id_wr_en,
  input  logic                                 id_is_load,
  input  logic [REG_ADDRESS_LENGTH-1:0]        id_rd,
  input  logic [NUM_READ*REG_ADDRESS_LENGTH-1:0] id_src,
  input  logic [NUM_READ-1:0]                  id_src_used,
  input  logic [NUM_READ*DATA_WIDTH-1:0]       rf_data,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]     stage_result,
  input  logic                                 flush,
  output logic                                 id_ready,
  output logic [NUM_READ*DATA_WIDTH-1:0]       opnd_data,
  output logic                                 wb_en,
  output logic [REG_ADDRESS_LENGTH-1:0]        wb_rd
);

  entry_t [NUM_STAGES-1:0] entries;
  entry_t                  new_entry;
  logic [NUM_READ-1:0]     port_hazard;
  logic                    stall;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    fwd_select #(
      .DATA_WIDTH         (DATA_WIDTH),
      .REG_ADDRESS_LENGTH (REG_ADDRESS_LENGTH),
      .NUM_STAGES         (NUM_STAGES)
    ) u_fwd (
      .src          (id_src[k*REG_ADDRESS_LENGTH +: REG_ADDRESS_LENGTH]),
      .src_used     (id_src_used[k]),
      .entries      (entries),
      .stage_result (stage_result),
      .rf_data      (rf_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .opnd_data    (opnd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .hazard       (port_hazard[k])
    );
  end

  // Stall only a live, unflushed instruction; a flushed one is dead so ID is free.
  always_comb begin
    stall    = id_valid & (|port_hazard) & ~flush;
    id_ready = ~stall;
  end

  // Build the entry entering stage 0: the issuing instruction, or a bubble on stall/flush/idle.
  always_comb begin
    new_entry = BUBBLE;
    if (id_valid & ~stall & ~flush) begin
      new_entry.valid   = 1'b1;
      new_entry.wr_en   = id_wr_en;
      new_entry.is_load = id_is_load;
      new_entry.rd[REG_ADDRESS_LENGTH-1:0] = id_rd;
`ifdef HAZARD_ZERO_REG_EN
      if (id_rd == '0) begin
        new_entry.wr_en = 1'b0;
      end
`endif
    end
  end

  // Advance every stage each cycle; reset empties the whole pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries <= {NUM_STAGES{BUBBLE}};
    end else begin
      entries[0] <= new_entry;
      for (int s = 1; s < NUM_STAGES; s++) begin
        entries[s] <= entries[s-1];
      end
    end
  end

  // Writeback comes from the oldest slot with no extra register stage.
  always_comb begin
    wb_en = entries[NUM_STAGES-1].valid & entries[NUM_STAGES-1].wr_en;
    wb_rd = entries[NUM_STAGES-1].rd[REG_ADDRESS_LENGTH-1:0];
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, then random traffic against an age-based reference model.
module tb_hazard_scoreboard;

  localparam int DW  = 64;
  localparam int RAL = 5;
  localparam int NS  = 3;
  localparam int NR  = 2;
`ifdef HAZARD_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  localparam logic [63:0] F0 = 64'hF0;
  localparam logic [63:0] F1 = 64'hF1;
  localparam logic [63:0] BB = 64'hBB;
  localparam logic [63:0] S1 = 64'h11;
  localparam logic [63:0] AA = 64'hAA;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid = 1'b0;
  logic              id_wr_en = 1'b0;
  logic              id_is_load = 1'b0;
  logic [RAL-1:0]    id_rd = '0;
  logic [NR*RAL-1:0] id_src = '0;
  logic [NR-1:0]     id_src_used = '0;
  logic [NR*DW-1:0]  rf_data = '0;
  logic [NS*DW-1:0]  stage_result = '0;
  logic              flush = 1'b0;
  logic              id_ready;
  logic [NR*DW-1:0]  opnd_data;
  logic              wb_en;
  logic [RAL-1:0]    wb_rd;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .DATA_WIDTH(DW), .REG_ADDRESS_LENGTH(RAL), .NUM_STAGES(NS), .NUM_READ(NR)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used), .rf_data(rf_data),
    .stage_result(stage_result), .flush(flush), .id_ready(id_ready), .opnd_data(opnd_data),
    .wb_en(wb_en), .wb_rd(wb_rd)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  // One directed cycle: inputs plus the outputs expected before the next edge.
  typedef struct {
    bit          rstn, vld, wr, ld, fl;
    logic [4:0]  rd, s0, s1;
    logic [1:0]  used;
    bit          e_rdy, e_we;
    logic [63:0] e_op0, e_op1;
    logic [4:0]  e_wrd;
  } vec_t;

  function automatic vec_t mk(input int rstn, input int vld, input int wr, input int ld, input int rd,
                              input int s0, input int s1, input int used, input int fl,
                              input int rdy, input logic [63:0] o0, input logic [63:0] o1,
                              input int we, input int wrd);
    vec_t r;
    r.rstn = rstn[0]; r.vld = vld[0]; r.wr = wr[0]; r.ld = ld[0]; r.fl = fl[0];
    r.rd = 5'(rd); r.s0 = 5'(s0); r.s1 = 5'(s1); r.used = 2'(used);
    r.e_rdy = rdy[0]; r.e_op0 = o0; r.e_op1 = o1; r.e_we = we[0]; r.e_wrd = 5'(wrd);
    return r;
  endfunction

  function automatic vec_t idle(input int we, input int wrd);
    return mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1, F0, F1, we, wrd);
  endfunction

  function automatic vec_t issue(input int rd, input int ld);
    return mk(1, 1, 1, ld, rd, 1, 2, 0, 0, 1, F0, F1, 0, 0);
  endfunction

  // Reference model: issued instructions remembered with their issue cycle; stage = age - 1.
  typedef struct {
    int         icyc;
    bit         wr;
    bit         ld;
    logic [4:0] rd;
  } rec_t;

  rec_t hist[$];
  int   cyc = 0;

  task automatic model_step(input int n);
    logic [63:0] exp_op [NR];
    logic [4:0]  sk;
    logic [4:0]  exp_wrd;
    bit          hz, stall, exp_we;
    int          best, st;
    #1;
    hz = 1'b0;
    for (int k = 0; k < NR; k++) begin
      sk = id_src[k*RAL +: RAL];
      exp_op[k] = rf_data[k*DW +: DW];
      best = NS;
      if (ZERO_EN && sk == 5'd0) begin
        exp_op[k] = '0;
      end else if (id_src_used[k]) begin
        foreach (hist[i]) begin
          st = cyc - hist[i].icyc - 1;
          if (hist[i].wr && hist[i].rd == sk && st >= 0 && st < NS) begin
            if (st < best) best = st;
            if (hist[i].ld && st < NS - 1) hz = 1'b1;
          end
        end
      end
      if (best < NS) exp_op[k] = stage_result[best*DW +: DW];
    end
    stall = id_valid && hz && !flush;
    exp_we = 1'b0;
    exp_wrd = '0;
    foreach (hist[i]) begin
      if (cyc - hist[i].icyc - 1 == NS - 1) begin
        exp_we = hist[i].wr;
        exp_wrd = hist[i].rd;
      end
    end
    chk($sformatf("rnd%0d id_ready", n), 64'(id_ready), 64'(!stall));
    chk($sformatf("rnd%0d opnd0", n), opnd_data[0 +: DW], exp_op[0]);
    chk($sformatf("rnd%0d opnd1", n), opnd_data[DW +: DW], exp_op[1]);
    chk($sformatf("rnd%0d wb_en", n), 64'(wb_en), 64'(exp_we));
    chk($sformatf("rnd%0d wb_rd", n), 64'(wb_rd), 64'(exp_wrd));
    @(posedge clk);
    if (!rst) hist.delete();
    else if (id_valid && !stall && !flush)
      hist.push_back('{cyc, id_wr_en && !(ZERO_EN && id_rd == 5'd0), id_is_load, id_rd});
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].icyc - 1 >= NS) void'(hist.pop_front());
  endtask

  vec_t tbl[$];
  localparam logic [63:0] Z_OP = ZERO_EN ? 64'h0 : BB;
  localparam int          R0_WE = ZERO_EN ? 0 : 1;

  initial begin
    // Back-to-back ALU chain
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 3, 1, 2, 3, 0, 1, F0, F1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4, 3, 3, 3, 0, 1, BB, BB, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(1, 3));
    tbl.push_back(idle(1, 4));
    // Load-use: two stall cycles then WB copy forwarded
    tbl.push_back(issue(5, 1));
    tbl.push_back(mk(1, 1, 1, 0, 6, 5, 9, 1, 0, 0, BB, F1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 6, 5, 9, 1, 0, 0, S1, F1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 6, 5, 9, 1, 0, 1, AA, F1, 1, 5));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(1, 6));
    // Load-use killed by flush
    tbl.push_back(issue(5, 1));
    tbl.push_back(mk(1, 1, 1, 0, 6, 5, 9, 1, 1, 1, BB, F1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8, 1, 2, 3, 0, 1, F0, F1, 0, 0));
    tbl.push_back(idle(1, 5));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(1, 8));
    // Youngest wins
    tbl.push_back(issue(7, 0));
    tbl.push_back(issue(9, 0));
    tbl.push_back(issue(7, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 7, 3, 0, 1, BB, BB, 1, 7));
    tbl.push_back(idle(1, 9));
    tbl.push_back(idle(1, 7));
    // Register 0
    tbl.push_back(issue(0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3, 0, 1, Z_OP, Z_OP, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(R0_WE, 0));
    tbl.push_back(idle(0, 0));
    // Reset with three live entries
    tbl.push_back(issue(10, 0));
    tbl.push_back(issue(11, 0));
    tbl.push_back(issue(12, 0));
    tbl.push_back(mk(0, 1, 1, 0, 13, 10, 9, 1, 0, 1, AA, F1, 1, 10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 11, 3, 0, 1, F0, F1, 0, 0));

    rf_data      = {F1, F0};
    stage_result = {AA, S1, BB};
    rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst         = tbl[i].rstn;
      id_valid    = tbl[i].vld;
      id_wr_en    = tbl[i].wr;
      id_is_load  = tbl[i].ld;
      id_rd       = tbl[i].rd;
      id_src      = {tbl[i].s1, tbl[i].s0};
      id_src_used = tbl[i].used;
      flush       = tbl[i].fl;
      #1;
      chk($sformatf("v%0d id_ready", i), 64'(id_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d opnd0", i), opnd_data[0 +: DW], tbl[i].e_op0);
      chk($sformatf("v%0d opnd1", i), opnd_data[DW +: DW], tbl[i].e_op1);
      chk($sformatf("v%0d wb_en", i), 64'(wb_en), 64'(tbl[i].e_we));
      chk($sformatf("v%0d wb_rd", i), 64'(wb_rd), 64'(tbl[i].e_wrd));
      @(posedge clk);
    end

    // Clean start for the random phase.
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    hist.delete();
    cyc = 0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 63) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_wr_en     = ($urandom_range(0, 4) != 0);
      id_is_load   = ($urandom_range(0, 3) == 0);
      id_rd        = 5'($urandom_range(0, 7));
      id_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_used  = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 7) == 0);
      rf_data      = {$urandom, $urandom, $urandom, $urandom};
      stage_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_step(n);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
